// File: rtl/hidden_weight_update_if.sv
// Host-side bundle for hidden_weight_update: pass control, hidden deltas and inputs,
// weight load/readback port, and pass status.
interface hidden_weight_update_if #(
  parameter int NUM_HID = 5,
  parameter int NUM_IN  = 3,
  parameter int AW      = $clog2(NUM_HID * NUM_IN)
);
  logic                 start;
  logic signed [9:0]    delta0 [NUM_HID];
  logic        [9:0]    x_in   [NUM_IN];
  logic                 wr_en;
  logic        [AW-1:0] wr_addr;
  logic signed [9:0]    wr_data;
  logic        [AW-1:0] rd_addr;
  logic signed [9:0]    rd_data;
  logic                 busy;
  logic                 done;

  modport master (
    output start, delta0, x_in, wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data, busy, done
  );

  modport slave (
    input  start, delta0, x_in, wr_en, wr_addr, wr_data, rd_addr,
    output rd_data, busy, done
  );
endinterface

// File: rtl/hidden_weight_update.sv
// Input->hidden weight register file with a sequential update pass, w -= LR*delta*x/1e6.
// Optional macro HIDDEN_WEIGHT_SAT_EN: clamp updated weights instead of wrapping to 10 bits.
module hidden_weight_update #(
  parameter int NUM_HID = 5,
  parameter int NUM_IN  = 3,
  parameter int LR      = 500,
  parameter int AW      = $clog2(NUM_HID * NUM_IN)
) (
  input logic                  clk,
  input logic                  rst_n,
  hidden_weight_update_if.slave bus
);

  localparam int NUM_W = NUM_HID * NUM_IN;
  localparam int JW    = (NUM_HID > 1) ? $clog2(NUM_HID) : 1;
  localparam int IW    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic signed [31:0] LR_S = 32'(LR);

  typedef enum logic [1:0] {IDLE, LOAD, UPDATE, FIN} state_t;

  state_t            state_reg, state_next;
  logic [JW-1:0]     j_reg, j_next;
  logic [IW-1:0]     i_reg, i_next;
  logic signed [9:0] delta_reg [NUM_HID];
  logic        [9:0] x_reg     [NUM_IN];
  logic signed [9:0] w_reg     [NUM_W];

  logic              w_we;
  logic [AW-1:0]     w_addr;
  logic signed [9:0] w_data;
  logic [NUM_W-1:0]  w_sel;
  logic              busy_c, done_c;

  logic [AW-1:0]      upd_addr;
  logic signed [31:0] d_ext, x_ext, prod, step;
  logic signed [11:0] w_ext, step12, wn_wide;
  logic signed [9:0]  wn;

  assign upd_addr = AW'(32'(j_reg) * NUM_IN + 32'(i_reg));

  // |step| <= 512*1023*LR/1e6, so the low 12 bits of step are exact for LR <= 1000.
  always_comb begin
    d_ext   = delta_reg[j_reg];
    x_ext   = {22'd0, x_reg[i_reg]};
    prod    = d_ext * x_ext * LR_S;
    step    = prod / 32'sd1000000;
    step12  = step[11:0];
    w_ext   = w_reg[upd_addr];
    wn_wide = w_ext - step12;
`ifdef HIDDEN_WEIGHT_SAT_EN
    if (wn_wide > 12'sd511) begin
      wn = 10'sh1FF;
    end else if (wn_wide < -12'sd512) begin
      wn = 10'sh200;
    end else begin
      wn = wn_wide[9:0];
    end
`else
    wn = wn_wide[9:0];
`endif
  end

  always_comb begin
    state_next = state_reg;
    j_next     = j_reg;
    i_next     = i_reg;
    w_we       = 1'b0;
    w_addr     = bus.wr_addr;
    w_data     = bus.wr_data;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    case (state_reg)
      IDLE: begin
        // Host writes share the weight port with the pass, so they only land while idle.
        w_we = bus.wr_en;
        if (bus.start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        busy_c     = 1'b1;
        j_next     = '0;
        i_next     = '0;
        state_next = UPDATE;
      end
      UPDATE: begin
        busy_c = 1'b1;
        w_we   = 1'b1;
        w_addr = upd_addr;
        w_data = wn;
        if (i_reg == IW'(NUM_IN - 1)) begin
          i_next = '0;
          if (j_reg == JW'(NUM_HID - 1)) begin
            j_next     = '0;
            state_next = FIN;
          end else begin
            j_next = j_reg + 1'b1;
          end
        end else begin
          i_next = i_reg + 1'b1;
        end
      end
      FIN: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < NUM_W; gi++) begin : g_wsel
    assign w_sel[gi] = w_we && (w_addr == AW'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      j_reg     <= '0;
      i_reg     <= '0;
      for (int k = 0; k < NUM_HID; k++) delta_reg[k] <= '0;
      for (int k = 0; k < NUM_IN; k++)  x_reg[k]     <= '0;
      for (int k = 0; k < NUM_W; k++)   w_reg[k]     <= '0;
    end else begin
      state_reg <= state_next;
      j_reg     <= j_next;
      i_reg     <= i_next;
      if (state_reg == LOAD) begin
        for (int k = 0; k < NUM_HID; k++) delta_reg[k] <= bus.delta0[k];
        for (int k = 0; k < NUM_IN; k++)  x_reg[k]     <= bus.x_in[k];
      end
      for (int k = 0; k < NUM_W; k++) begin
        if (w_sel[k]) w_reg[k] <= w_data;
      end
    end
  end

  assign bus.rd_data = (32'(bus.rd_addr) < NUM_W) ? w_reg[bus.rd_addr] : '0;
  assign bus.busy    = busy_c;
  assign bus.done    = done_c;

endmodule

// File: tb/tb_hidden_weight_update.sv
// Directed bench for hidden_weight_update: two instances (LR=500, LR=1000) share stimulus.
module tb_hidden_weight_update;
  localparam int NUM_HID = 5;
  localparam int NUM_IN  = 3;
  localparam int AW      = 4;
  localparam int NUM_W   = NUM_HID * NUM_IN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 start_s = 1'b0;
  logic signed [9:0]    delta_s [NUM_HID];
  logic        [9:0]    x_s     [NUM_IN];
  logic                 wr_en_s = 1'b0;
  logic        [AW-1:0] wr_addr_s = '0;
  logic signed [9:0]    wr_data_s = '0;
  logic        [AW-1:0] rd_addr_s = '0;

  hidden_weight_update_if #(.NUM_HID(NUM_HID), .NUM_IN(NUM_IN), .AW(AW)) if_a ();
  hidden_weight_update_if #(.NUM_HID(NUM_HID), .NUM_IN(NUM_IN), .AW(AW)) if_b ();

  hidden_weight_update #(.NUM_HID(NUM_HID), .NUM_IN(NUM_IN), .LR(500), .AW(AW)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  hidden_weight_update #(.NUM_HID(NUM_HID), .NUM_IN(NUM_IN), .LR(1000), .AW(AW)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  assign if_a.start = start_s;    assign if_b.start = start_s;
  assign if_a.wr_en = wr_en_s;    assign if_b.wr_en = wr_en_s;
  assign if_a.wr_addr = wr_addr_s; assign if_b.wr_addr = wr_addr_s;
  assign if_a.wr_data = wr_data_s; assign if_b.wr_data = wr_data_s;
  assign if_a.rd_addr = rd_addr_s; assign if_b.rd_addr = rd_addr_s;
  for (genvar gi = 0; gi < NUM_HID; gi++) begin : g_d
    assign if_a.delta0[gi] = delta_s[gi];
    assign if_b.delta0[gi] = delta_s[gi];
  end
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_x
    assign if_a.x_in[gi] = x_s[gi];
    assign if_b.x_in[gi] = x_s[gi];
  end

  typedef struct {
    bit lr_hi; int addr; int w_init; int dj; int dval; int xi; int xval; int exp_sat; int exp_wrap;
  } vec_t;

  int checks = 0;
  int errors = 0;
  bit cur_lr;
  int cur_addr, cur_w, cur_exp;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [31:0] rd_sel(input bit hi);
    return hi ? 32'(if_b.rd_data) : 32'(if_a.rd_data);
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic host_write(input int addr, input int data);
    wr_en_s = 1'b1;
    wr_addr_s = AW'(addr);
    wr_data_s = 10'(data);
    @(negedge clk);
    wr_en_s = 1'b0;
  endtask

  task automatic setup_inputs(input int dj, input int dval, input int xi, input int xval);
    for (int k = 0; k < NUM_HID; k++) delta_s[k] = '0;
    for (int k = 0; k < NUM_IN; k++)  x_s[k] = '0;
    delta_s[dj] = 10'(dval);
    x_s[xi] = 10'(xval);
  endtask

  // mode 0 normal, 1 extra start/write mid-pass, 2 reset mid-pass, 3 write together with start.
  task automatic run_pass(input int mode, output int done_cyc, output int busy_cnt, output int done_cnt);
    done_cyc = -1; busy_cnt = 0; done_cnt = 0;
    rd_addr_s = AW'(cur_addr);
    start_s = 1'b1;
    if (mode == 3) begin
      wr_en_s = 1'b1; wr_addr_s = AW'(cur_addr); wr_data_s = 10'(cur_w);
    end
    @(posedge clk);
    @(negedge clk);
    start_s = 1'b0;
    wr_en_s = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if ((cur_lr ? if_b.busy : if_a.busy) === 1'b1) busy_cnt++;
      if ((cur_lr ? if_b.done : if_a.done) === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (k == 2 + cur_addr) chk("rd_before_update", rd_sel(cur_lr), cur_w);
      if (k == 3 + cur_addr) chk("rd_after_update", rd_sel(cur_lr), cur_exp);
      if (k == 2) begin
        for (int m = 0; m < NUM_HID; m++) delta_s[m] = 10'sd300;
        for (int m = 0; m < NUM_IN; m++)  x_s[m] = 10'd700;
      end
      if (mode == 1 && k == 5) start_s = 1'b1;
      if (mode == 1 && k == 6) begin
        start_s = 1'b0; wr_en_s = 1'b1; wr_addr_s = '0; wr_data_s = 10'sd55;
      end
      if (mode == 1 && k == 7) wr_en_s = 1'b0;
      if (mode == 2 && k == 8) begin
        rst_n = 1'b0;
        #1;
        chk("busy_in_reset_a", 32'(if_a.busy), 0);
        chk("done_in_reset_a", 32'(if_a.done), 0);
        chk("busy_in_reset_b", 32'(if_b.busy), 0);
      end
      if (mode == 2 && k == 9) begin
        for (int a = 0; a < NUM_W; a++) begin
          rd_addr_s = AW'(a);
          #1;
          chk("rd_cleared", rd_sel(1'b0), 0);
        end
        rd_addr_s = AW'(cur_addr);
      end
      if (mode == 2 && k == 10) rst_n = 1'b1;
      @(negedge clk);
    end
  endtask

  vec_t vecs[8];
  int dc, bc, nc, exp_v;

  initial begin
    vecs[0] = '{0, 0,  100, 0,  200, 0, 1000,    0,    0};
    vecs[1] = '{1, 0, -500, 0,  511, 0, 1000, -512,   13};
    vecs[2] = '{1, 0,    7, 0,   -3, 0,    1,    7,    7};
    vecs[3] = '{0, 7,   20, 2, -100, 1, 1000,   70,   70};
    vecs[4] = '{0, 14,  -3, 4,   10, 2, 1000,   -8,   -8};
    vecs[5] = '{1, 5,    0, 1, -512, 2, 1023,  511, -501};
    vecs[6] = '{0, 3,  511, 1,   -2, 0, 1000,  511, -512};
    vecs[7] = '{0, 9,    0, 3,    1, 0,  999,    0,    0};
    setup_inputs(0, 0, 0, 0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(if_a.busy), 0);
    chk("reset_done", 32'(if_a.done), 0);
    for (int a = 0; a < NUM_W; a += 7) begin
      rd_addr_s = AW'(a);
      #1;
      chk("reset_rd", rd_sel(1'b0), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
`ifdef HIDDEN_WEIGHT_SAT_EN
      exp_v = vecs[v].exp_sat;
`else
      exp_v = vecs[v].exp_wrap;
`endif
      pulse_reset();
      setup_inputs(vecs[v].dj, vecs[v].dval, vecs[v].xi, vecs[v].xval);
      host_write(vecs[v].addr, vecs[v].w_init);
      cur_lr = vecs[v].lr_hi; cur_addr = vecs[v].addr; cur_w = vecs[v].w_init; cur_exp = exp_v;
      run_pass(0, dc, bc, nc);
      chk("done_cycle", dc, 17);
      chk("done_count", nc, 1);
      chk("busy_cycles", bc, 16);
      chk("final_weight", rd_sel(cur_lr), exp_v);
      rd_addr_s = AW'((cur_addr + 1) % NUM_W);
      #1;
      chk("neighbour_weight", rd_sel(cur_lr), 0);
      $display("vec %0d lr_hi %0d addr %0d w_init %0d result %0d expected %0d",
               v, cur_lr, cur_addr, cur_w, rd_sel(cur_lr), exp_v);
    end

    // Extra start and host write mid-pass are both dropped
    pulse_reset();
    setup_inputs(0, 200, 0, 1000);
    host_write(0, 100);
    cur_lr = 0; cur_addr = 0; cur_w = 100; cur_exp = 0;
    run_pass(1, dc, bc, nc);
    chk("ignore_done_count", nc, 1);
    chk("ignore_done_cycle", dc, 17);
    rd_addr_s = '0;
    #1;
    chk("ignore_weight", rd_sel(1'b0), 0);
    $display("seq ignore: done_count %0d w0 %0d", nc, rd_sel(1'b0));

    // Reset mid-pass aborts with no done, then a fresh pass runs normally
    pulse_reset();
    setup_inputs(0, 200, 0, 1000);
    host_write(0, 100);
    run_pass(2, dc, bc, nc);
    chk("abort_no_done", nc, 0);
    setup_inputs(0, 200, 0, 1000);
    host_write(0, 100);
    run_pass(0, dc, bc, nc);
    chk("after_abort_done", dc, 17);
    chk("after_abort_weight", rd_sel(1'b0), 0);
    $display("seq abort: restart done_cycle %0d w0 %0d", dc, rd_sel(1'b0));

    // Host write in the same cycle as start feeds the pass
    pulse_reset();
    setup_inputs(0, 200, 0, 1000);
    run_pass(3, dc, bc, nc);
    chk("same_cycle_done", dc, 17);
    chk("same_cycle_weight", rd_sel(1'b0), 0);
    $display("seq same-cycle write+start: w0 %0d", rd_sel(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
